// File: rtl/trap_eval_pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : Pu_types                                                     |
// | Purpose : Shared types for the fixed-point trap path.                  |
// |           - Trap_to: the 5-bit TO field.                               |
// |           - TO_* : bit positions of each condition inside Trap_to.     |
// |           - pack_flags(): places the compare flags at those bits.      |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package Pu_types;

  typedef logic [4:0] Trap_to;

  localparam int TO_LT  = 4;  // a <  b, signed
  localparam int TO_GT  = 3;  // a >  b, signed
  localparam int TO_EQ  = 2;  // a == b
  localparam int TO_LTU = 1;  // a <  b, unsigned
  localparam int TO_GTU = 0;  // a >  b, unsigned

  function automatic Trap_to pack_flags(input logic lt_s, input logic gt_s,
                                        input logic eq, input logic lt_u,
                                        input logic gt_u);
    Trap_to f;
    f         = '0;
    f[TO_LT]  = lt_s;
    f[TO_GT]  = gt_s;
    f[TO_EQ]  = eq;
    f[TO_LTU] = lt_u;
    f[TO_GTU] = gt_u;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_eval_pipe_compare.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : trap_compare                                                 |
// | Purpose : Combinational Power trap-condition compare.                  |
// | Ports   : a, b  [DATA_W] operands                                      |
// |           dword          1 = 64-bit compare, 0 = word compare          |
// |           to    [5]      TO field selecting the conditions             |
// |           cause [5]      to AND compare flags                          |
// | Config  : NUX_TRAP_DWORD_EN enables the 64-bit compare path; without   |
// |           it dword is ignored and only bits [31:0] are compared.       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module trap_compare
  import Pu_types::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              dword,
  input  Trap_to            to,
  output Trap_to            cause
);

  // Word compare: signed flags read the low word as a two's complement value,
  // unsigned flags read it as a plain magnitude; bits above 31 never matter.
  logic signed [31:0] w_a_lo_s;
  logic signed [31:0] w_b_lo_s;
  Trap_to             w_word_flags;
  Trap_to             w_flags;

  assign w_a_lo_s     = a[31:0];
  assign w_b_lo_s     = b[31:0];
  assign w_word_flags = pack_flags(w_a_lo_s < w_b_lo_s, w_a_lo_s > w_b_lo_s,
                                   a[31:0] == b[31:0], a[31:0] < b[31:0],
                                   a[31:0] > b[31:0]);

`ifdef NUX_TRAP_DWORD_EN
  if (DATA_W >= 64) begin : g_dword
    logic signed [63:0] w_a_s;
    logic signed [63:0] w_b_s;
    Trap_to             w_dword_flags;

    assign w_a_s         = a[63:0];
    assign w_b_s         = b[63:0];
    assign w_dword_flags = pack_flags(w_a_s < w_b_s, w_a_s > w_b_s,
                                      a[63:0] == b[63:0], a[63:0] < b[63:0],
                                      a[63:0] > b[63:0]);
    assign w_flags       = dword ? w_dword_flags : w_word_flags;
  end else begin : g_word_only
    assign w_flags = w_word_flags;
  end
`else
  assign w_flags = w_word_flags;
`endif

  assign cause = to & w_flags;

  // Operand bits and dword that a given build does not compare.
  logic w_unused;
  assign w_unused = ^{dword, a, b};

endmodule
`default_nettype wire

// File: rtl/trap_eval_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : trap_eval_pipe                                               |
// | Purpose : Two-stage trap evaluator. S1 registers the operand pair, S2  |
// |           registers the compare result. A trapping S2 entry holds      |
// |           trap_req until trap_ack or flush; a clean entry pulses       |
// |           done_valid for one cycle.                                    |
// | Ports   : clk, reset (sync, active low)                                |
// |           in_valid/in_ready, in_a, in_b, in_to, in_dword, in_tag       |
// |           flush            drop every in-flight entry                  |
// |           trap_req/trap_tag/trap_cause, trap_ack                       |
// |           done_valid/done_tag                                          |
// |           trap_count       saturating count of acknowledged traps      |
// | Config  : NUX_TRAP_DWORD_EN enables in_dword (64-bit compare).         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module trap_eval_pipe
  import Pu_types::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [4:0]        in_to,
  input  logic              in_dword,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              trap_req,
  output logic [TAG_W-1:0]  trap_tag,
  output logic [4:0]        trap_cause,
  input  logic              trap_ack,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic [CNT_W-1:0]  trap_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  Trap_to            s1_to_q;
  logic              s1_dword_q;
  logic [TAG_W-1:0]  s1_tag_q;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_trap_q;
  Trap_to            s2_cause_q;
  logic [TAG_W-1:0]  s2_tag_q;

  logic [CNT_W-1:0]  count_q, count_d;

  Trap_to            w_cause;
  logic              w_accept;
  logic              w_s1_adv;
  logic              w_taken;

  trap_compare #(.DATA_W(DATA_W)) u_cmp (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .dword (s1_dword_q),
    .to    (s1_to_q),
    .cause (w_cause)
  );

  // A clean S2 entry always leaves after its done cycle, so only an
  // unacknowledged trap blocks S1; this keeps full throughput without traps.
  assign w_s1_adv = s1_valid_q & (~s2_valid_q | ~s2_trap_q | trap_ack);
  assign in_ready = ~s1_valid_q | w_s1_adv;
  assign w_accept = in_valid & in_ready;
  assign w_taken  = trap_req & trap_ack;

  assign trap_req   = s2_valid_q & s2_trap_q;
  assign trap_tag   = trap_req ? s2_tag_q : '0;
  assign trap_cause = trap_req ? s2_cause_q : '0;
  assign done_valid = s2_valid_q & ~s2_trap_q;
  assign done_tag   = done_valid ? s2_tag_q : '0;
  assign trap_count = count_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s2_valid_q && (!s2_trap_q || trap_ack)) s2_valid_d = 1'b0;
    if (w_s1_adv) begin
      s2_valid_d = 1'b1;
      s1_valid_d = 1'b0;
    end
    if (w_accept) s1_valid_d = 1'b1;
    // Flush wins over everything, including a same-cycle handshake.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // A trap acknowledged in a flush cycle still counts as taken.
  always_comb begin
    count_d = count_q;
    if (w_taken && (count_q != CNT_MAX)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_to_q    <= '0;
      s1_dword_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_trap_q  <= 1'b0;
      s2_cause_q <= '0;
      s2_tag_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      count_q    <= count_d;
      if (w_accept) begin
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_to_q    <= in_to;
        s1_dword_q <= in_dword;
        s1_tag_q   <= in_tag;
      end
      if (w_s1_adv) begin
        s2_trap_q  <= |w_cause;
        s2_cause_q <= w_cause;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

endmodule
`default_nettype wire
